// File: rtl/afe_cfg_sequencer.sv
// AFE2256 configuration sequencer: plays a built-in register init sequence over
// an SPI engine and arbitrates single CPU register accesses onto the same engine.
module afe_cfg_sequencer #(
  parameter int RESET_WAIT_CYC = 1000,
  parameter int TRIM_WAIT_CYC  = 500,
  parameter int GAP_CYC        = 8,
  parameter int TIMEOUT_CYC    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_init,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [6:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_done,
  output logic [15:0] cpu_rdata,
  input  logic        spi_ready,
  output logic        spi_start,
  output logic [23:0] spi_word,
  input  logic        spi_done,
  input  logic [15:0] spi_rdata,
  output logic        init_busy,
  output logic        init_done,
  output logic        err_timeout
);

  // Handshakes: cpu_req is a level held by the CPU until the cpu_ack pulse;
  // spi_start is a one-cycle pulse accepted only while spi_ready=1, and the
  // engine answers with a one-cycle spi_done pulse carrying spi_rdata.

  localparam int MAX_AB  = (RESET_WAIT_CYC > TRIM_WAIT_CYC) ? RESET_WAIT_CYC : TRIM_WAIT_CYC;
  localparam int MAX_CD  = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [3:0] LAST_IDX = 4'd12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    DELAY     = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t        state, state_d;
  logic          src_cpu, src_cpu_d;
  logic [3:0]    idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          req_rw, req_rw_d;
  logic [6:0]    req_addr, req_addr_d;
  logic [15:0]   req_wdata, req_wdata_d;
  logic          cpu_ack_d, cpu_done_d, spi_start_d;
  logic [15:0]   cpu_rdata_d;
  logic [23:0]   spi_word_d;
  logic          init_busy_d, init_done_d, err_timeout_d;

  function automatic logic [22:0] rom_entry(input logic [3:0] i);
    case (i)
      4'd0:    rom_entry = {7'h00, 16'h0001};
      4'd1:    rom_entry = {7'h30, 16'h0002};
      4'd2:    rom_entry = {7'h11, 16'h2830};
      4'd3:    rom_entry = {7'h12, 16'h4000};
      4'd4:    rom_entry = {7'h16, 16'h00C0};
      4'd5:    rom_entry = {7'h18, 16'h0001};
      4'd6:    rom_entry = {7'h2C, 16'h0000};
      4'd7:    rom_entry = {7'h61, 16'h4000};
      4'd8:    rom_entry = {7'h5E, 16'h0000};
      4'd9:    rom_entry = {7'h5C, 16'h4800};
      4'd10:   rom_entry = {7'h5D, 16'h0002};
      4'd11:   rom_entry = {7'h13, 16'h0020};
      4'd12:   rom_entry = {7'h10, 16'h03C0};
      default: rom_entry = 23'h0;
    endcase
  endfunction

  always_comb begin
    state_d       = state;
    src_cpu_d     = src_cpu;
    idx_d         = idx;
    cnt_d         = cnt;
    req_rw_d      = req_rw;
    req_addr_d    = req_addr;
    req_wdata_d   = req_wdata;
    cpu_ack_d     = 1'b0;
    cpu_done_d    = 1'b0;
    cpu_rdata_d   = cpu_rdata;
    spi_start_d   = 1'b0;
    spi_word_d    = spi_word;
    init_busy_d   = init_busy;
    init_done_d   = init_done;
    err_timeout_d = err_timeout;
    case (state)
      IDLE: begin
        if (start_init && !init_busy) begin
          init_done_d   = 1'b0;
          err_timeout_d = 1'b0;
          init_busy_d   = 1'b1;
          idx_d         = 4'd0;
          src_cpu_d     = 1'b0;
          state_d       = ISSUE;
        end else if (cpu_req && !init_busy) begin
          cpu_ack_d   = 1'b1;
          req_rw_d    = cpu_rw;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          src_cpu_d   = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (spi_ready) begin
          spi_start_d = 1'b1;
          // Reads carry an all-zero data field.
          spi_word_d  = src_cpu ? {req_rw, req_addr, (req_rw ? 16'h0000 : req_wdata)}
                                : {1'b0, rom_entry(idx)};
          cnt_d       = CW'(TIMEOUT_CYC);
          state_d     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (spi_done) begin
          if (src_cpu) begin
            cpu_done_d = 1'b1;
            if (req_rw) cpu_rdata_d = spi_rdata;
          end
          if (!src_cpu && idx == 4'd0) begin
            cnt_d   = CW'(RESET_WAIT_CYC);
            state_d = DELAY;
          end else if (!src_cpu && idx == 4'd1) begin
            cnt_d   = CW'(TRIM_WAIT_CYC);
            state_d = DELAY;
          end else begin
            cnt_d   = CW'(GAP_CYC);
            state_d = GAP;
          end
        end else if (cnt <= CW'(1)) begin
          err_timeout_d = 1'b1;
          init_busy_d   = 1'b0;
          cnt_d         = '0;
          state_d       = IDLE;
          if (src_cpu) begin
            cpu_done_d  = 1'b1;
            cpu_rdata_d = 16'hFFFF;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      DELAY: begin
        if (cnt <= CW'(1)) begin
          cnt_d   = CW'(GAP_CYC);
          state_d = GAP;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt <= CW'(1)) begin
          cnt_d = '0;
          if (src_cpu) begin
            state_d = IDLE;
          end else if (idx == LAST_IDX) begin
            init_busy_d = 1'b0;
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d   = idx + 4'd1;
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      src_cpu     <= 1'b0;
      idx         <= 4'd0;
      cnt         <= '0;
      req_rw      <= 1'b0;
      req_addr    <= 7'h00;
      req_wdata   <= 16'h0000;
      cpu_ack     <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_rdata   <= 16'h0000;
      spi_start   <= 1'b0;
      spi_word    <= 24'h000000;
      init_busy   <= 1'b0;
      init_done   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      src_cpu     <= src_cpu_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      req_rw      <= req_rw_d;
      req_addr    <= req_addr_d;
      req_wdata   <= req_wdata_d;
      cpu_ack     <= cpu_ack_d;
      cpu_done    <= cpu_done_d;
      cpu_rdata   <= cpu_rdata_d;
      spi_start   <= spi_start_d;
      spi_word    <= spi_word_d;
      init_busy   <= init_busy_d;
      init_done   <= init_done_d;
      err_timeout <= err_timeout_d;
    end
  end

endmodule
